// File: rtl/marquee_scroll_ctrl.sv
// rtl/marquee_scroll_ctrl.sv - digit scan, debounced scroll control and ROM addressing for the 8-digit marquee
//
// Optional feature macro: MARQUEE_SPEED_TOGGLE_EN
//   defined   : a C press in STOP/LEFT/RIGHT (with no L/R press) toggles fast stepping
//   undefined : fast is tied to 0 and C in STOP is ignored
//
// Ports:
//   clk       in   1  system clock
//   rst_n     in   1  asynchronous active-low reset
//   btn_l     in   1  raw button, scroll left
//   btn_r     in   1  raw button, scroll right
//   btn_c     in   1  raw button, pause/resume (speed toggle when enabled)
//   scan_sel  out  3  index of the digit currently driven
//   an        out  8  anode enables, active low, one-cold
//   rom_addr  out  3  character ROM address = (scan_sel + offset) mod 8
//   state     out  2  00 STOP, 01 LEFT, 10 RIGHT, 11 PAUSE
//   fast      out  1  STEP_FAST period selected

module marquee_scroll_ctrl #(
  parameter int SCAN_DIV   = 100_000,
  parameter int STEP_SLOW  = 100_000_000,
  parameter int STEP_FAST  = 10_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  output logic [2:0] scan_sel,
  output logic [7:0] an,
  output logic [2:0] rom_addr,
  output logic [1:0] state,
  output logic       fast
);

  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STEP_MAX = (STEP_SLOW > STEP_FAST) ? STEP_SLOW : STEP_FAST;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);
  localparam int DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [SCAN_W-1:0] SCAN_TC = SCAN_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0] SLOW_TC = STEP_W'(STEP_SLOW - 1);
  localparam logic [STEP_W-1:0] FAST_TC = STEP_W'(STEP_FAST - 1);
  localparam logic [DEB_W-1:0]  DEB_TC  = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_LEFT  = 2'b01,
    ST_RIGHT = 2'b10,
    ST_PAUSE = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Digit scan
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        scan_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt   <= '0;
      scan_sel_q <= 3'd0;
    end else if (scan_cnt == SCAN_TC) begin
      scan_cnt   <= '0;
      scan_sel_q <= scan_sel_q + 3'd1;
    end else begin
      scan_cnt   <= scan_cnt + SCAN_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Button conditioning: bit 0 = L, bit 1 = R, bit 2 = C
  // ---------------------------------------------------------------------------
  logic [2:0]       btn_raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       deb;
  logic [2:0]       deb_prev;
  logic [2:0]       press_q;
  logic [DEB_W-1:0] deb_cnt [3];

  assign btn_raw = {btn_c, btn_r, btn_l};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // The counter measures how long the synced level has disagreed with the
  // accepted level; any agreement restarts the measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_TC) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Press pulse is registered so the FSM sees a clean single-cycle strobe
  // one edge after the debounced rise; releases produce nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_prev <= 3'b000;
      press_q  <= 3'b000;
    end else begin
      deb_prev <= deb;
      press_q  <= deb & ~deb_prev;
    end
  end

  logic pl;
  logic pr;
  logic pc;

  assign pl = press_q[0];
  assign pr = press_q[1];
  assign pc = press_q[2];

  // ---------------------------------------------------------------------------
  // Scroll FSM
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  state_t saved_dir_q;
  state_t saved_dir_d;
  logic   step_clr;
  logic   fast_q;
`ifdef MARQUEE_SPEED_TOGGLE_EN
  logic   fast_tgl;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STOP;
      saved_dir_q <= ST_LEFT;
    end else begin
      state_q     <= state_d;
      saved_dir_q <= saved_dir_d;
    end
  end

  // Simultaneous presses resolve L > R > C.
  always_comb begin
    state_d     = state_q;
    saved_dir_d = saved_dir_q;
    step_clr    = 1'b0;
`ifdef MARQUEE_SPEED_TOGGLE_EN
    fast_tgl    = 1'b0;
`endif
    case (state_q)
      ST_STOP: begin
        if (pl) begin
          state_d  = ST_LEFT;
          step_clr = 1'b1;
        end else if (pr) begin
          state_d  = ST_RIGHT;
          step_clr = 1'b1;
        end else if (pc) begin
`ifdef MARQUEE_SPEED_TOGGLE_EN
          fast_tgl = 1'b1;
`endif
        end
      end
      ST_LEFT: begin
        // A repeated L press leaves the running interval untouched.
        if (!pl) begin
          if (pr) begin
            state_d  = ST_RIGHT;
            step_clr = 1'b1;
          end else if (pc) begin
            state_d     = ST_PAUSE;
            saved_dir_d = ST_LEFT;
`ifdef MARQUEE_SPEED_TOGGLE_EN
            fast_tgl    = 1'b1;
`endif
          end
        end
      end
      ST_RIGHT: begin
        if (pl) begin
          state_d  = ST_LEFT;
          step_clr = 1'b1;
        end else if (!pr && pc) begin
          state_d     = ST_PAUSE;
          saved_dir_d = ST_RIGHT;
`ifdef MARQUEE_SPEED_TOGGLE_EN
          fast_tgl    = 1'b1;
`endif
        end
      end
      ST_PAUSE: begin
        // Resuming in the saved direction keeps the remaining interval;
        // switching direction starts a fresh one.
        if (pl) begin
          state_d  = ST_LEFT;
          step_clr = (saved_dir_q != ST_LEFT);
        end else if (pr) begin
          state_d  = ST_RIGHT;
          step_clr = (saved_dir_q != ST_RIGHT);
        end else if (pc) begin
          state_d  = saved_dir_q;
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
  end

`ifdef MARQUEE_SPEED_TOGGLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fast_q <= 1'b0;
    end else if (fast_tgl) begin
      fast_q <= ~fast_q;
    end
  end
`else
  assign fast_q = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Step timer and scroll offset
  // ---------------------------------------------------------------------------
  logic [STEP_W-1:0] step_cnt;
  logic [2:0]        offset_q;
  logic              step_run;
  logic              step_tc;

  assign step_run = (state_q == ST_LEFT) || (state_q == ST_RIGHT);
  // ">=" rather than "==" so that switching to the shorter period while the
  // timer is already past it still produces a step on the next edge.
  assign step_tc  = (step_cnt >= (fast_q ? FAST_TC : SLOW_TC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      offset_q <= 3'd0;
    end else begin
      if (step_run && step_tc) begin
        if (state_q == ST_LEFT) offset_q <= offset_q + 3'd1;
        else                    offset_q <= offset_q - 3'd1;
      end
      if (step_clr || (step_run && step_tc)) begin
        step_cnt <= '0;
      end else if (step_run) begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: an and rom_addr derive from the same registered values
  // ---------------------------------------------------------------------------
  assign scan_sel = scan_sel_q;
  assign an       = ~(8'b0000_0001 << scan_sel_q);
  assign rom_addr = scan_sel_q + offset_q;
  assign state    = state_q;
  assign fast     = fast_q;

endmodule

// File: tb/tb_marquee_scroll_ctrl.sv
// tb/tb_marquee_scroll_ctrl.sv - scoreboard bench for marquee_scroll_ctrl
`timescale 1ns/1ps

module tb_marquee_scroll_ctrl;

  localparam logic [1:0] STOP  = 2'b00;
  localparam logic [1:0] LEFT  = 2'b01;
  localparam logic [1:0] RIGHT = 2'b10;
  localparam logic [1:0] PAUSE = 2'b11;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_l = 1'b0;
  logic       btn_r = 1'b0;
  logic       btn_c = 1'b0;
  logic [2:0] scan_sel;
  logic [7:0] an;
  logic [2:0] rom_addr;
  logic [1:0] state;
  logic       fast;

  always #5 clk = ~clk;

  marquee_scroll_ctrl #(
    .SCAN_DIV   (4),
    .STEP_SLOW  (32),
    .STEP_FAST  (8),
    .DEB_CYCLES (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_l    (btn_l),
    .btn_r    (btn_r),
    .btn_c    (btn_c),
    .scan_sel (scan_sel),
    .an       (an),
    .rom_addr (rom_addr),
    .state    (state),
    .fast     (fast)
  );

  // Edge count since reset release; cleared asynchronously with the DUT.
  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         at;
    logic [1:0] st;
    int         off;
    logic       fst;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic span(input int from, input int to, input logic [1:0] st,
                      input int off, input logic fst, input string name);
    exp_t e;
    for (int c = from; c <= to; c++) begin
      e.at   = c;
      e.st   = st;
      e.off  = off;
      e.fst  = fst;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic check_entry(input exp_t e);
    logic [2:0] es;
    logic [7:0] ea;
    logic [2:0] er;
    es = 3'((e.at / 4) % 8);
    ea = ~(8'b0000_0001 << es);
    er = 3'(((e.at / 4) + e.off) % 8);
    checks++;
    if (scan_sel !== es || an !== ea || rom_addr !== er || state !== e.st || fast !== e.fst) begin
      errors++;
      $display("FAIL %s cyc=%0d got sel=%0d an=%h rom=%0d st=%0d fast=%0b required sel=%0d an=%h rom=%0d st=%0d fast=%0b",
               e.name, e.at, scan_sel, an, rom_addr, state, fast, es, ea, er, e.st, e.fst);
    end
  endtask

  // Monitor: compare every expectation whose cycle tag has come up.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check_entry(sb[i]);
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed: tagged cyc=%0d now cyc=%0d", sb[i].name, sb[i].at, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic goto(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 5000) begin
      @(posedge clk);
      #2;
      guard++;
    end
  endtask

  task automatic wait_empty(input string name);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    // Reset state
    span(0, 0, STOP, 0, 1'b0, "reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: free-running scan
    span(1, 39, STOP, 0, 1'b0, "idle_scan");

    // 2: left press, 8+ steps with wrap 7->0
    goto(40);
    span(40, 46, STOP, 0, 1'b0, "left_latency");
    for (int n = 0; n < 10; n++)
      span(47 + 32 * n, 78 + 32 * n, LEFT, n % 8, 1'b0, "left_step");
    span(367, 376, LEFT, 2, 1'b0, "left_off2");
    btn_l = 1'b1;
    goto(52);
    btn_l = 1'b0;

    // 3: right from LEFT at offset 2, 2->1->0->7
    goto(370);
    span(377, 408, RIGHT, 2, 1'b0, "right_clr");
    span(409, 440, RIGHT, 1, 1'b0, "right_step1");
    span(441, 472, RIGHT, 0, 1'b0, "right_step0");
    span(473, 496, RIGHT, 7, 1'b0, "right_wrap7");
    btn_r = 1'b1;
    goto(382);
    btn_r = 1'b0;

    // 4a: two-cycle glitch on L is rejected
    goto(480);
    btn_l = 1'b1;
    goto(482);
    btn_l = 1'b0;

    // 4b/5: C press with one-cycle dropout, freeze, resume, L+R from PAUSE
    goto(490);
`ifdef MARQUEE_SPEED_TOGGLE_EN
    span(497, 536, PAUSE, 7, 1'b1, "pause_dropout");
    span(537, 544, LEFT, 7, 1'b1, "left_from_pause");
    span(545, 552, LEFT, 0, 1'b1, "left_fast_step");
    span(553, 556, LEFT, 1, 1'b1, "left_fast_step2");
    span(557, 666, PAUSE, 1, 1'b0, "pause_freeze");
    span(667, 694, LEFT, 1, 1'b0, "resume_left");
    span(695, 706, LEFT, 2, 1'b0, "resume_step");
    span(707, 736, PAUSE, 2, 1'b1, "pause2");
    span(737, 737, LEFT, 2, 1'b1, "lr_resume");
    span(738, 745, LEFT, 3, 1'b1, "fast_overrun_step");
    span(746, 753, LEFT, 4, 1'b1, "fast_step_a");
    span(754, 761, LEFT, 5, 1'b1, "fast_step_b");
    span(762, 765, LEFT, 6, 1'b1, "fast_step_c");
`else
    span(497, 536, PAUSE, 7, 1'b0, "pause_dropout");
    span(537, 556, LEFT, 7, 1'b0, "left_from_pause");
    span(557, 666, PAUSE, 7, 1'b0, "pause_freeze");
    span(667, 678, LEFT, 7, 1'b0, "resume_left");
    span(679, 706, LEFT, 0, 1'b0, "resume_step");
    span(707, 736, PAUSE, 0, 1'b0, "pause2");
    span(737, 740, LEFT, 0, 1'b0, "lr_resume");
    span(741, 765, LEFT, 1, 1'b0, "lr_resume_step");
`endif
    btn_c = 1'b1;
    goto(500);
    btn_c = 1'b0;
    goto(501);
    btn_c = 1'b1;
    goto(510);
    btn_c = 1'b0;
    goto(530);
    btn_l = 1'b1;
    goto(542);
    btn_l = 1'b0;
    goto(550);
    btn_c = 1'b1;
    goto(562);
    btn_c = 1'b0;
    goto(660);
    btn_c = 1'b1;
    goto(672);
    btn_c = 1'b0;
    goto(700);
    btn_c = 1'b1;
    goto(712);
    btn_c = 1'b0;
    goto(730);
    btn_l = 1'b1;
    btn_r = 1'b1;
    goto(742);
    btn_l = 1'b0;
    btn_r = 1'b0;

    // 6a: async reset mid-step and mid-debounce; held R restarts from scratch
    goto(766);
    btn_r = 1'b1;
    goto(769);
    wait_empty("drain1");
    span(0, 0, STOP, 0, 1'b0, "rst_async_1");
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    span(1, 6, STOP, 0, 1'b0, "rst_deb_restart");
    span(7, 38, RIGHT, 0, 1'b0, "right_after_rst");
    span(39, 45, RIGHT, 7, 1'b0, "right_wrap_0_7");
    goto(10);
    btn_r = 1'b0;

    // 6b: second async reset, then C in STOP, then L
    goto(46);
    wait_empty("drain2");
    span(0, 0, STOP, 0, 1'b0, "rst_async_2");
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    span(1, 11, STOP, 0, 1'b0, "stop_pre_c");
`ifdef MARQUEE_SPEED_TOGGLE_EN
    span(12, 36, STOP, 0, 1'b1, "stop_c_toggle");
    span(37, 44, LEFT, 0, 1'b1, "fast_left");
    span(45, 52, LEFT, 1, 1'b1, "fast_left_1");
    span(53, 60, LEFT, 2, 1'b1, "fast_left_2");
    span(61, 68, LEFT, 3, 1'b1, "fast_left_3");
    span(69, 75, LEFT, 4, 1'b1, "fast_left_4");
`else
    span(12, 36, STOP, 0, 1'b0, "stop_c_ignored");
    span(37, 68, LEFT, 0, 1'b0, "slow_left");
    span(69, 75, LEFT, 1, 1'b0, "slow_left_1");
`endif
    goto(5);
    btn_c = 1'b1;
    goto(17);
    btn_c = 1'b0;
    goto(30);
    btn_l = 1'b1;
    goto(42);
    btn_l = 1'b0;

    goto(76);
    wait_empty("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
